// File: rtl/instr_mem_pkg.sv
// Shared definitions for the multi-core instruction store.
// Holds opcode constants, the controller state encoding, default widths
// and a small index-width helper used by the store and its arbiter.
package instr_mem_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_NUM_CORES = 4;

    // Opcodes with a fixed meaning to the memory system. END is also the
    // word returned for out-of-range fetches so a runaway core halts.
    localparam logic [15:0] OP_SETN    = 16'd0;
    localparam logic [15:0] OP_SETC    = 16'd1;
    localparam logic [15:0] OP_END     = 16'd25;
    localparam logic [15:0] OP_MVTR2   = 16'd26;
    localparam logic [15:0] OP_MVACTR2 = 16'd27;
    localparam logic [15:0] OP_LDTR2   = 16'd28;

    // Controller states
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    // Bits needed to index n items; never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   req       : request vector
//   en        : allows the pointer to advance past the granted requester
//   gnt       : one-hot grant (combinational)
//   idx       : index of the granted requester (valid when gnt != 0)
// The search starts at the pointer and wraps, so the most recently served
// requester has the lowest priority on the next cycle.
module rr_arbiter
    import instr_mem_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_mc.sv
// Instruction store shared by NUM_CORES fetch ports.
// After reset the array is zero-filled (CLEAR); in RUN one fetch per cycle
// is granted round-robin with a registered one-cycle read; in LOAD the host
// writes program words and fetches are stalled.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   init_done          : zero-fill finished
//   load_en            : request LOAD mode
//   wr_valid/addr/data : host write; wr_ready high in LOAD
//   wr_err             : pulse after a dropped out-of-range write
//   rd_req, rd_addr    : per-core fetch requests, packed addresses
//   rd_gnt             : one-hot grant, same cycle
//   rd_valid, rd_data  : one-hot owner and fetched word, next cycle
//   rd_err             : fetch address was out of range
module instr_mem_mc
    import instr_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int END_OPCODE = 25
) (
    input  logic                        clk,
    input  logic                        rstn,
    output logic                        init_done,
    input  logic                        load_en,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic                        wr_err,
    input  logic [NUM_CORES-1:0]        rd_req,
    input  logic [NUM_CORES*ADDR_W-1:0] rd_addr,
    output logic [NUM_CORES-1:0]        rd_gnt,
    output logic [NUM_CORES-1:0]        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_err
);

    localparam int                MEM_AW   = idx_w(DEPTH);
    localparam int                IW       = idx_w(NUM_CORES);
    localparam logic [DATA_W-1:0] END_WORD = DATA_W'(END_OPCODE);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(DEPTH);

    logic [1:0]           state;
    logic [MEM_AW-1:0]    clr_cnt;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic [NUM_CORES-1:0] arb_req;
    logic [IW-1:0]        gnt_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 any_gnt;
    logic                 rd_in_range;
    logic                 wr_in_range;
    logic                 wr_fire;

    // Requests reach the arbiter only in RUN and not while a switch to LOAD
    // is pending, so no grant is issued in the transition cycle.
    assign arb_req = (state == ST_RUN && !load_en) ? rd_req : '0;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (arb_req),
        .en   (1'b1),
        .gnt  (rd_gnt),
        .idx  (gnt_idx)
    );

    assign any_gnt     = |rd_gnt;
    assign sel_addr    = rd_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign rd_in_range = {1'b0, sel_addr} < LIMIT;
    assign wr_in_range = {1'b0, wr_addr} < LIMIT;
    assign wr_ready    = (state == ST_LOAD);
    assign wr_fire     = wr_ready && wr_valid;

    // Controller
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == MEM_AW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_RUN:  if (load_en)  state <= ST_LOAD;
                ST_LOAD: if (!load_en) state <= ST_RUN;
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Array write port: zero-fill in CLEAR, host writes in LOAD. Reads only
    // happen in RUN, so the two never collide in the same cycle.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire && wr_in_range) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    // Registered read / status outputs; rd_data holds between fetches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= '0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
            rd_err   <= any_gnt && !rd_in_range;
            wr_err   <= wr_fire && !wr_in_range;
            if (any_gnt) begin
                rd_data <= rd_in_range ? mem[sel_addr[MEM_AW-1:0]] : END_WORD;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_mc.sv
// Scoreboard bench for instr_mem_mc: the driver pushes the expected fetch
// response when it issues a request, the monitor pops on every rd_valid.
module tb_instr_mem_mc;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int NC     = 4;

    typedef struct packed {
        logic [NC-1:0]     vld;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 init_done;
    logic                 load_en;
    logic                 wr_valid;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_ready;
    logic                 wr_err;
    logic [NC-1:0]        rd_req;
    logic [NC*ADDR_W-1:0] rd_addr;
    logic [NC-1:0]        rd_gnt;
    logic [NC-1:0]        rd_valid;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_err;

    exp_t              sb[$];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    int                exp_ptr;
    int                tests = 0;
    int                fails = 0;

    instr_mem_mc #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .NUM_CORES(NC), .END_OPCODE(25)
    ) dut (
        .clk(clk), .rstn(rstn), .init_done(init_done), .load_en(load_en),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented fetch result must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_valid", 32'(rd_valid), 32'(e.vld));
                    check("rd_data",  32'(rd_data),  32'(e.data));
                    check("rd_err",   32'(rd_err),   32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    function automatic exp_t mk(input int core, input logic [DATA_W-1:0] d,
                                input logic e);
        exp_t x;
        x.vld  = NC'(1 << core);
        x.data = d;
        x.err  = e;
        return x;
    endfunction

    // Called from release of rstn (between edges); counts edges to init_done.
    // rd_req and load_en may be left high on entry: CLEAR must ignore them.
    task automatic wait_init();
        int n = 0;
        while (!init_done && n < DEPTH + 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                check("gnt_in_clear",   32'(rd_gnt),   32'd0);
                check("wr_ready_clear", 32'(wr_ready), 32'd0);
                rd_req  = '0;
                load_en = 1'b0;
            end
        end
        check("init_latency", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_ptr = 0;
    endtask

    // All tasks below start and end 1ns after a rising edge.
    task automatic fetch(input int core, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic e);
        rd_req = '0;
        rd_req[core] = 1'b1;
        rd_addr[core*ADDR_W +: ADDR_W] = a;
        @(negedge clk);
        check("gnt_single", 32'(rd_gnt), 32'(1 << core));
        sb.push_back(mk(core, d, e));
        exp_ptr = (core + 1) % NC;
        @(posedge clk); #1;
        rd_req = '0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic exp_err);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        check("wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check("wr_err", 32'(wr_err), 32'(exp_err));
        if (32'(a) < DEPTH) exp_mem[a] = d;
    endtask

    task automatic enter_load();
        load_en = 1'b1;
        @(posedge clk); #1;
        check("wr_ready_load", 32'(wr_ready), 32'd1);
    endtask

    task automatic exit_load();
        load_en = 1'b0;
        @(posedge clk); #1;
        check("wr_ready_run", 32'(wr_ready), 32'd0);
    endtask

    task automatic all_cores(input int cycles);
        rd_req = '1;
        for (int c = 0; c < NC; c++) rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(c);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("gnt_rr", 32'(rd_gnt), 32'(1 << exp_ptr));
            sb.push_back(mk(exp_ptr, exp_mem[exp_ptr], 1'b0));
            exp_ptr = (exp_ptr + 1) % NC;
            @(posedge clk); #1;
        end
        rd_req = '0;
    endtask

    initial begin
        rstn = 1'b0; load_en = 1'b1; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; rd_req = '1; rd_addr = '0; exp_ptr = 0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_rd_err",    32'(rd_err),    32'd0);
        check("rst_wr_err",    32'(wr_err),    32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_gnt",       32'(rd_gnt),    32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wait_init();

        // Idle fetch after zero-fill
        fetch(3, 16'd5, 16'h0000, 1'b0);

        // Program load and fetch-back
        enter_load();
        wr(16'd0,  16'h0000, 1'b0);
        wr(16'd1,  16'h03E6, 1'b0);
        wr(16'd35, 16'h0019, 1'b0);
        wr(16'd2,  16'h1234, 1'b0);
        wr(16'd3,  16'hBEEF, 1'b0);
        wr(16'd44, 16'h4444, 1'b0);
        exit_load();
        fetch(0, 16'd1,  16'h03E6, 1'b0);
        fetch(1, 16'd35, 16'h0019, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("rd_data_hold",  32'(rd_data),  32'h0019);
        check("rd_valid_idle", 32'(rd_valid), 32'd0);

        // Fairness: all cores requesting
        all_cores(8);

        // Out-of-range fetch and write
        fetch(2, 16'd300, 16'd25, 1'b1);
        enter_load();
        wr(16'd300, 16'hAAAA, 1'b1);
        @(posedge clk); #1;
        check("wr_err_pulse_end", 32'(wr_err), 32'd0);
        exit_load();
        fetch(1, 16'd44, 16'h4444, 1'b0);

        // Mode collision: grant in the cycle before load_en, none after
        all_cores(1);
        rd_req  = '1;
        load_en = 1'b1;
        @(negedge clk);
        check("gnt_mode_switch", 32'(rd_gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("gnt_in_load", 32'(rd_gnt), 32'd0);
        @(posedge clk); #1;
        rd_req = '0;
        exit_load();

        // Reset mid-LOAD
        fetch(0, 16'd1, 16'h03E6, 1'b0);
        @(posedge clk); #1;
        enter_load();
        wr(16'd5,   16'h5555, 1'b0);
        wr(16'd300, 16'hAAAA, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_wr_err",    32'(wr_err),    32'd0);
        check("mid_rst_rd_data",   32'(rd_data),   32'd0);
        check("mid_rst_rd_valid",  32'(rd_valid),  32'd0);
        check("mid_rst_wr_ready",  32'(wr_ready),  32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        rd_req = '1;
        @(negedge clk);
        rstn = 1'b1;
        wait_init();
        all_cores(1);
        fetch(1, 16'd5, 16'h0000, 1'b0);
        fetch(3, 16'd1, 16'h0000, 1'b0);

        repeat (3) @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_mc.md
Name: instr_mem_mc

Overview:
- Parametrised, clocked instruction store shared by NUM_CORES processing cores, each fetching program words through its own request port.
- A round-robin arbiter serves one fetch per cycle, with one-cycle registered read latency.
- A load port lets the host write the program at run time instead of fixing it at elaboration.
- After reset the store zero-fills itself, and out-of-range fetches return an END opcode so a runaway core halts.

Parameters:
- DATA_W, 16, instruction word width.
- ADDR_W, 16, address width on all ports.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W.
- NUM_CORES, 4, number of fetch ports; must be >= 1.
- END_OPCODE, 25, word returned for out-of-range fetches.

Ports:
- clk, in, 1, system clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- init_done, out, 1, high once the zero-fill is finished.
- load_en, in, 1, selects LOAD mode; fetches are stalled while high.
- wr_valid, in, 1, write request; only honoured in LOAD.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- wr_ready, out, 1, high in LOAD state (combinational from state).
- wr_err, out, 1, one-cycle pulse after an accepted write to an address >= DEPTH.
- rd_req, in, NUM_CORES, per-core fetch request; held until granted.
- rd_addr, in, NUM_CORES*ADDR_W, packed fetch addresses; core c uses slice [c*ADDR_W +: ADDR_W].
- rd_gnt, out, NUM_CORES, one-hot grant, combinational, same cycle as acceptance.
- rd_valid, out, NUM_CORES, one-hot, registered; marks which core owns rd_data this cycle.
- rd_data, out, DATA_W, registered fetched word.
- rd_err, out, 1, registered; high with rd_valid when the fetch address was >= DEPTH.

Behaviour:
- Reset (rstn low, asynchronous):
  - rd_valid=0, rd_data=0, rd_err=0, wr_err=0, init_done=0.
  - Round-robin pointer = core 0.
  - State = CLEAR, clear counter = 0.
- CLEAR state:
  - Writes 0 to word [counter] each cycle; counter increments.
  - After writing DEPTH-1, go to RUN and set init_done=1 (DEPTH cycles total).
  - rd_gnt=0 and wr_ready=0 throughout.
  - load_en is ignored here.
- RUN state:
  - load_en=1 moves to LOAD next cycle; no grant is issued in the transition cycle.
  - Otherwise, if any rd_req bit is set, grant exactly one core: the first requesting core at or after the pointer, searching in increasing index with wrap.
  - After a grant, the pointer = granted index + 1, wrapping NUM_CORES-1 to 0.
  - No request: pointer unchanged, no grant.
  - Fetch data appears on the next cycle with rd_valid one-hot for the granted core.
  - Back-to-back grants give a sustained throughput of one word per cycle.
  - rd_data holds its last value when rd_valid=0.
- Out-of-range fetch (addr >= DEPTH):
  - rd_data = END_OPCODE truncated to DATA_W, rd_err=1.
  - The array is not accessed.
- LOAD state:
  - wr_ready=1; each cycle with wr_valid=1 writes wr_data to wr_addr.
  - Out-of-range writes are dropped, with a wr_err pulse on the next cycle.
  - load_en=0 returns to RUN next cycle.
  - A fetch accepted in the cycle before LOAD still completes normally.
- Read/write ordering:
  - A write followed by a fetch of the same address on a later cycle returns the new data.
  - The LOAD-to-RUN turnaround rules out same-cycle conflicts.
- Reset asserted mid-LOAD or mid-CLEAR aborts the operation and restarts CLEAR from 0. Array contents are undefined until CLEAR completes.
- Throughout:
  - At most one rd_gnt bit and one rd_valid bit are high in any cycle.
  - A request held without a grant must keep rd_addr stable.

Decomposition:
- Shared package instr_mem_pkg holds:
  - opcode constants (SETN=0, SETC=1, …, END=25, MVTR2=26, MVACTR2=27, LDTR2=28);
  - state encoding CLEAR/RUN/LOAD;
  - default widths.
- Sub-module rr_arbiter (parameter N): inputs req and the pointer update enable; outputs one-hot gnt and grant index. It is reused later for data-memory ports.

Test Plan:
- Reset then idle: init_done rises exactly DEPTH cycles after rstn deasserts; a fetch of addr 5 then returns 0.
- Program load: LOAD writes 0x0000@0, 0x03E6@1, 0x0019@35; back in RUN, core 0 fetches 1 and gets 0x03E6 with rd_valid=0001 one cycle after rd_gnt.
- Fairness with NUM_CORES=4: all cores request continuously with addrs 0..3. Grants are 0,1,2,3,0,… and each rd_valid carries the matching word.
- Out of range: core 2 fetches addr 300 with DEPTH=256 and gets rd_data=25, rd_err=1. A LOAD write to 300 gives a wr_err pulse, and address 44 (300 mod 256) is unchanged.
- Mode collision: load_en rises in a cycle with rd_req=1111. There is no grant that cycle, and a grant issued the previous cycle still delivers rd_valid.
- rstn pulsed low mid-LOAD: outputs clear immediately, CLEAR restarts, init_done is low for DEPTH cycles, and later fetches return 0.
